change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Pays out a credit balance as physical coins. This is the outbound counterpart of the
//  coin-acceptance control path: the inbound path turns coins into credit; this block
//  turns leftover credit into coin-eject pulses.
//  Greedy selection (largest coin first), one coin at a time, each confirmed by a drop sensor.
//  Sits between the vending datapath (supplies amount/start) and the three coin-tube solenoids.
// PARAMETERS
//  W          8    width of amount/remaining (cents)
//  VAL_HI     25   value of tube 2 coin
//  VAL_MID    10   value of tube 1 coin
//  VAL_LO     5    value of tube 0 coin
//  PULSE_LEN  4    cycles each eject solenoid pulse is held high (>=1)
//  GAP_LEN    4    idle cycles between coins (>=1)
//  TIMEOUT    255  max cycles waiting for coin_ok after a pulse ends
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, asynchronous, active-high
//  start      in   1   1-cycle request; amount sampled same edge; ignored while busy=1
//  amount     in   W   change to pay, cents
//  empty      in   3   tube-empty flags [2]=HI [1]=MID [0]=LO; sampled in SELECT only
//  coin_ok    in   1   drop-sensor pulse, coin left the machine; sampled in WAIT_ACK only
//  eject      out  3   one-hot solenoid drive, same bit order as empty
//  busy       out  1   high from the cycle after start until DONE/ERR completes
//  done       out  1   1-cycle completion pulse (success or failure)
//  err        out  1   sticky failure flag; cleared by next accepted start
//  remaining  out  W   credit not yet paid
// BEHAVIOUR
//  Reset: state=IDLE; eject=0, busy=0, done=0, err=0, remaining=0.
//   Reset mid-operation drops eject at once (async) and abandons the payout.
//  States: IDLE, SELECT, EJECT, WAIT_ACK, GAP, DONE, FAIL.
//  IDLE: busy=0. On start: remaining<=amount, err<=0, goto SELECT.
//  SELECT (1 cycle): first match wins, in this order:
//   remaining==0 -> DONE;
//   remaining>=VAL_HI && !empty[2] -> tube 2;
//   else remaining>=VAL_MID && !empty[1] -> tube 1;
//   else remaining>=VAL_LO && !empty[0] -> tube 0;
//   else -> FAIL (remaining unchanged).
//   On a coin choice: latch tube index k, goto EJECT.
//  EJECT: eject[k]=1 for exactly PULSE_LEN cycles, then WAIT_ACK. Only one eject bit high, ever.
//  WAIT_ACK: eject=0.
//   On coin_ok: remaining<=remaining-VAL_k, goto GAP.
//   If TIMEOUT cycles pass with no coin_ok -> FAIL.
//   coin_ok in any other state is ignored.
//  GAP: GAP_LEN cycles, eject=0, then SELECT.
//  DONE: done=1 one cycle, busy=1; next IDLE.
//  FAIL: done=1 and err<=1 one cycle, busy=1; next IDLE. remaining keeps the unpaid balance.
//  Latency: start at edge 0 -> SELECT in cycle 1 -> eject high cycles 2..PULSE_LEN+1.
//  Subtraction never underflows: a coin is chosen only if VAL_k <= remaining.
//  start with amount==0 -> SELECT -> DONE; no eject, err=0.
//  start while busy=1 -> ignored; amount is not re-sampled.
// TESTING
//  1 amount=40, empty=000, coin_ok 2 cycles after each pulse ->
//    eject 100,010,001 in order; done once; remaining 0; err 0.
//  2 amount=30, empty=100 -> three eject=010 pulses; remaining 30->20->10->0; done; err 0.
//  3 amount=7, empty=000 -> one eject=001 pulse, then FAIL: done=1, err=1, remaining=2.
//  4 amount=25, coin_ok never asserted -> eject=100 for 4 cycles;
//    after 255 cycles in WAIT_ACK: done=1, err=1, remaining=25.
//  5 start(amount=10) while busy -> second start and amount ignored; one 010 pulse only.
//  6 rst asserted mid-EJECT -> eject=000 same cycle;
//    after release: busy=0, remaining=0, no further pulses.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending datapath / coin hardware and the change dispenser.
// master = datapath and sensors side, slave = dispenser.
interface change_dispenser_if #(
   parameter int W = 8
) ();
   logic         start;
   logic [W-1:0] amount;
   logic [2:0]   empty;
   logic         coin_ok;
   logic [2:0]   eject;
   logic         busy;
   logic         done;
   logic         err;
   logic [W-1:0] remaining;

   modport master (
      output start, amount, empty, coin_ok,
      input  eject, busy, done, err, remaining
   );

   modport slave (
      input  start, amount, empty, coin_ok,
      output eject, busy, done, err, remaining
   );
endinterface

// File: rtl/change_dispenser.sv
// Pays out a credit balance one coin at a time, largest coin first, each coin
// confirmed by the drop sensor before the next one is selected.
module change_dispenser #(
   parameter int W         = 8,
   parameter int VAL_HI    = 25,
   parameter int VAL_MID   = 10,
   parameter int VAL_LO    = 5,
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 4,
   parameter int TIMEOUT   = 255
) (
   input logic               clk,
   input logic               rst,
   change_dispenser_if.slave bus
);

   localparam int PG_MAX  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int CNT_MAX = (TIMEOUT > PG_MAX) ? TIMEOUT : PG_MAX;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE, SELECT, EJECT, WAIT_ACK, GAP, DONE, FAIL
   } state_t;

   state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]   k, k_nxt;
   logic [W-1:0] rem_q, rem_nxt;
   logic         err_q, err_nxt;
   logic [2:0]   eject_c;
   logic         busy_c, done_c;

   function automatic logic [W-1:0] coin_val(input logic [1:0] idx);
      case (idx)
         2'd2:    coin_val = W'(VAL_HI);
         2'd1:    coin_val = W'(VAL_MID);
         default: coin_val = W'(VAL_LO);
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         k     <= '0;
         rem_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         k     <= k_nxt;
         rem_q <= rem_nxt;
         err_q <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      k_nxt     = k;
      rem_nxt   = rem_q;
      err_nxt   = err_q;
      eject_c   = 3'b000;
      busy_c    = 1'b1;
      done_c    = 1'b0;
      unique case (state)
         IDLE: begin
            busy_c = 1'b0;
            if (bus.start) begin
               rem_nxt   = bus.amount;
               err_nxt   = 1'b0;
               state_nxt = SELECT;
            end
         end
         SELECT: begin
            cnt_nxt = '0;
            // Each coin is only eligible if it fits, so the later subtraction cannot underflow
            if (rem_q == '0) begin
               state_nxt = DONE;
            end else if (rem_q >= W'(VAL_HI) && !bus.empty[2]) begin
               k_nxt     = 2'd2;
               state_nxt = EJECT;
            end else if (rem_q >= W'(VAL_MID) && !bus.empty[1]) begin
               k_nxt     = 2'd1;
               state_nxt = EJECT;
            end else if (rem_q >= W'(VAL_LO) && !bus.empty[0]) begin
               k_nxt     = 2'd0;
               state_nxt = EJECT;
            end else begin
               err_nxt   = 1'b1;
               state_nxt = FAIL;
            end
         end
         EJECT: begin
            eject_c = 3'b001 << k;
            if (cnt == CNT_W'(PULSE_LEN - 1)) begin
               cnt_nxt   = '0;
               state_nxt = WAIT_ACK;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WAIT_ACK: begin
            if (bus.coin_ok) begin
               rem_nxt   = rem_q - coin_val(k);
               cnt_nxt   = '0;
               state_nxt = GAP;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               err_nxt   = 1'b1;
               state_nxt = FAIL;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == CNT_W'(GAP_LEN - 1)) begin
               cnt_nxt   = '0;
               state_nxt = SELECT;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: begin
            done_c    = 1'b1;
            state_nxt = IDLE;
         end
         FAIL: begin
            done_c    = 1'b1;
            err_nxt   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Eject decodes straight from state so an async reset drops the solenoid immediately
   assign bus.eject     = eject_c;
   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.err       = err_q;
   assign bus.remaining = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of payouts plus hand-written
// busy-restart and mid-eject reset sequences.
module tb_change_dispenser;

   localparam int PULSE_LEN = 4;
   localparam int TIMEOUT   = 255;
   localparam int BUDGET    = 900;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   change_dispenser_if #(.W(8)) bus ();

   change_dispenser #(
      .W(8), .VAL_HI(25), .VAL_MID(10), .VAL_LO(5),
      .PULSE_LEN(PULSE_LEN), .GAP_LEN(4), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   typedef struct {
      logic [7:0]  amount;
      logic [2:0]  empty;
      bit          ack;
      bit          dbl;
      int          np;
      logic [11:0] pulses;
      logic [7:0]  rem;
      bit          err;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int         cyc, np, width, ackcd, end_cyc, done_cyc;
      logic [2:0] prev;
      bit         seen_done;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.amount = v.amount;
      bus.empty  = v.empty;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.amount = 8'hFF;
      cyc = 1; np = 0; width = 0; ackcd = -1; end_cyc = 0; done_cyc = 0;
      prev = 3'b000; seen_done = 1'b0;
      while (!seen_done && cyc < BUDGET) begin
         bus.coin_ok = (ackcd == 0);
         if (ackcd >= 0) ackcd--;
         if (v.dbl && cyc == 3) begin
            bus.start  = 1'b1;
            bus.amount = 8'd40;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.eject != 3'b000) begin
            chk($sformatf("v%0d onehot", idx), int'($onehot(bus.eject)), 1);
            if (prev == 3'b000) begin
               if (np == 0) chk($sformatf("v%0d first_pulse_cycle", idx), cyc, 2);
               chk($sformatf("v%0d pulse_in_budget", idx), int'(np < v.np), 1);
               if (np < v.np)
                  chk($sformatf("v%0d pulse%0d_value", idx, np), int'(bus.eject),
                      int'(v.pulses[np*3 +: 3]));
               np++;
               width = 1;
            end else begin
               width++;
            end
         end else if (prev != 3'b000) begin
            chk($sformatf("v%0d pulse_width", idx), width, PULSE_LEN);
            end_cyc = cyc;
            if (v.ack) ackcd = 1;
         end
         if (bus.done) begin
            seen_done = 1'b1;
            done_cyc  = cyc;
         end
         prev = bus.eject;
         if (!seen_done) begin
            @(negedge clk);
            cyc++;
         end
      end
      bus.start   = 1'b0;
      bus.coin_ok = 1'b0;
      chk($sformatf("v%0d done_seen", idx), int'(seen_done), 1);
      chk($sformatf("v%0d remaining", idx), int'(bus.remaining), int'(v.rem));
      chk($sformatf("v%0d pulse_count", idx), np, v.np);
      if (!v.ack && v.np > 0)
         chk($sformatf("v%0d timeout_len", idx), done_cyc - end_cyc, TIMEOUT);
      @(negedge clk);
      chk($sformatf("v%0d done_one_cycle", idx), int'(bus.done), 0);
      chk($sformatf("v%0d busy_after", idx), int'(bus.busy), 0);
      chk($sformatf("v%0d err", idx), int'(bus.err), int'(v.err));
   endtask

   initial begin
      int nz;
      bit hit;
      bus.start = 1'b0; bus.amount = 8'd0; bus.empty = 3'b000; bus.coin_ok = 1'b0;

      //          amount empty  ack   dbl   np pulses (p0 in [2:0])  rem    err
      vecs[0]  = '{8'd40, 3'b000, 1'b1, 1'b0, 3, 12'b000_001_010_100, 8'd0,  1'b0};
      vecs[1]  = '{8'd30, 3'b100, 1'b1, 1'b0, 3, 12'b000_010_010_010, 8'd0,  1'b0};
      vecs[2]  = '{8'd7,  3'b000, 1'b1, 1'b0, 1, 12'b000_000_000_001, 8'd2,  1'b1};
      vecs[3]  = '{8'd25, 3'b000, 1'b0, 1'b0, 1, 12'b000_000_000_100, 8'd25, 1'b1};
      vecs[4]  = '{8'd0,  3'b000, 1'b1, 1'b0, 0, 12'b000_000_000_000, 8'd0,  1'b0};
      vecs[5]  = '{8'd65, 3'b000, 1'b1, 1'b0, 4, 12'b001_010_100_100, 8'd0,  1'b0};
      vecs[6]  = '{8'd15, 3'b011, 1'b1, 1'b0, 0, 12'b000_000_000_000, 8'd15, 1'b1};
      vecs[7]  = '{8'd35, 3'b001, 1'b1, 1'b0, 2, 12'b000_000_010_100, 8'd0,  1'b0};
      vecs[8]  = '{8'd12, 3'b000, 1'b1, 1'b0, 1, 12'b000_000_000_010, 8'd2,  1'b1};
      vecs[9]  = '{8'd10, 3'b000, 1'b1, 1'b1, 1, 12'b000_000_000_010, 8'd0,  1'b0};
      vecs[10] = '{8'd5,  3'b110, 1'b1, 1'b0, 1, 12'b000_000_000_001, 8'd0,  1'b0};

      repeat (3) @(negedge clk);
      chk("reset eject", int'(bus.eject), 0);
      chk("reset busy", int'(bus.busy), 0);
      chk("reset done", int'(bus.done), 0);
      chk("reset err", int'(bus.err), 0);
      chk("reset remaining", int'(bus.remaining), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // Reset while a coin is being ejected
      @(negedge clk);
      bus.start = 1'b1; bus.amount = 8'd25; bus.empty = 3'b000;
      @(negedge clk);
      bus.start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 10 && !hit; c++) begin
         @(negedge clk);
         if (bus.eject != 3'b000) hit = 1'b1;
      end
      chk("rst_mid eject_seen", int'(hit), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid eject_dropped", int'(bus.eject), 0);
      chk("rst_mid busy_dropped", int'(bus.busy), 0);
      @(negedge clk);
      rst = 1'b0;
      nz = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.eject != 3'b000 || bus.busy) nz++;
      end
      chk("rst_mid no_activity", nz, 0);
      chk("rst_mid remaining", int'(bus.remaining), 0);
      chk("rst_mid err", int'(bus.err), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
